// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous front-end for an asynchronous SRAM.
// Accepts one read/write request at a time and sequences the SRAM chip
// select, output enable and write enable through setup, strobe and hold
// phases whose lengths are set at elaboration time. The shared data bus is
// driven only during writes. Read data is registered, and a one-cycle done
// pulse marks the end of each transaction.
module sram_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  req,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addrIn,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sramAddr,
    inout  wire  [DATA_WIDTH-1:0] sramData,
    output logic                  notOE,
    output logic                  notWE,
    output logic                  notCS
);

    // The phase counter is 8 bits wide, so every phase length must be 1..255.
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255 ||
        PULSE_CYCLES < 1 || PULSE_CYCLES > 255 ||
        HOLD_CYCLES  < 1 || HOLD_CYCLES  > 255) begin : g_bad_params
        $error("sram_ctrl: SETUP/PULSE/HOLD_CYCLES must each be in 1..255");
    end

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // The counter is loaded with length-1 and the phase ends when it reaches zero.
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  last_cycle;
    logic                  in_access;
    logic                  drive_en;

    assign last_cycle = (cnt_q == 8'd0);

    // Next-state logic: walk IDLE->SETUP->PULSE->HOLD->DONE and latch the request only in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    write_d = write;
                    addr_d  = addrIn;
                    wdata_d = wdata;
                end
            end
            ST_SETUP: begin
                if (last_cycle) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_PULSE: begin
                if (last_cycle) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    if (!write_q) begin
                        rdata_d = sramData;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (last_cycle) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset returns to IDLE at once and clears the read data.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode directly from state so an asynchronous reset releases them immediately.
    always_comb begin
        in_access = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_HOLD);
        notCS     = ~in_access;
        notOE     = ~(~write_q && ((state_q == ST_SETUP) || (state_q == ST_PULSE)));
        notWE     = ~(write_q && (state_q == ST_PULSE));
        drive_en  = write_q && in_access;
    end

    assign sramData = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign rdata    = rdata_q;
    assign sramAddr = addr_q;

endmodule
